// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program counter generator and fetch-request controller
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_target_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              ce_o,
    output logic              redirect_pending_o,
    output logic              misalign_o,
    output logic [ADDR_W-1:0] misalign_addr_o
);

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-1:0] RST_ADDR   = RESET_PC[ADDR_W-1:0];

    state_t            state;
    logic [ADDR_W-1:0] pend_target;
    logic [ADDR_W-1:0] redir_target;
    logic [ADDR_W-1:0] pc_next_seq;
    logic              redir_misaligned;
    logic              flush_misaligned;

    // A live ID-stage branch takes precedence over a previously captured one.
    assign redir_target     = branch_flag_i ? branch_target_i : pend_target;
    assign redir_misaligned = (redir_target[1:0] != 2'b00);
    assign flush_misaligned = (flush_target_i[1:0] != 2'b00);
    assign pc_next_seq      = pc_o + STEP;

    assign redirect_pending_o = (state == S_PEND);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_RST;
            pc_o            <= RST_ADDR;
            ce_o            <= 1'b0;
            pend_target     <= '0;
            misalign_o      <= 1'b0;
            misalign_addr_o <= '0;
        end else begin
            misalign_o <= 1'b0;
            case (state)
                S_RST: begin
                    // pc_o stays at RESET_PC so that address is fetched exactly once.
                    ce_o  <= 1'b1;
                    state <= S_RUN;
                end
                default: begin
                    ce_o <= 1'b1;
                    if (flush_i) begin
                        pc_o        <= flush_target_i & ALIGN_MASK;
                        pend_target <= '0;
                        state       <= S_RUN;
                        if (flush_misaligned) begin
                            misalign_o      <= 1'b1;
                            misalign_addr_o <= flush_target_i;
                        end
                    end else if (stall_i) begin
                        // Capture is stored unchecked; alignment is judged when consumed.
                        if (branch_flag_i) begin
                            pend_target <= branch_target_i;
                            state       <= S_PEND;
                        end
                    end else if (branch_flag_i || (state == S_PEND)) begin
                        pend_target <= '0;
                        state       <= S_RUN;
                        if (redir_misaligned) begin
                            pc_o            <= pc_next_seq;
                            misalign_o      <= 1'b1;
                            misalign_addr_o <= redir_target;
                        end else begin
                            pc_o <= redir_target;
                        end
                    end else begin
                        pc_o <= pc_next_seq;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] flush_target_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic [31:0] pc_o;
    logic        ce_o;
    logic        redirect_pending_o;
    logic        misalign_o;
    logic [31:0] misalign_addr_o;

    int n_checks = 0;
    int n_fails  = 0;

    pc_fetch_ctrl #(
        .RESET_PC(32'h0000_0000),
        .ADDR_W  (32),
        .PC_STEP (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall_i),
        .flush_i           (flush_i),
        .flush_target_i    (flush_target_i),
        .branch_flag_i     (branch_flag_i),
        .branch_target_i   (branch_target_i),
        .pc_o              (pc_o),
        .ce_o              (ce_o),
        .redirect_pending_o(redirect_pending_o),
        .misalign_o        (misalign_o),
        .misalign_addr_o   (misalign_addr_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_i       = 1'b0;
        flush_i       = 1'b0;
        branch_flag_i = 1'b0;
    endtask

    task automatic expect_state(input string tag, input logic [31:0] pc, input logic pend, input logic mis);
        check_eq({tag, ".pc"}, pc_o, pc);
        check_eq({tag, ".pend"}, {31'b0, redirect_pending_o}, {31'b0, pend});
        check_eq({tag, ".mis"}, {31'b0, misalign_o}, {31'b0, mis});
    endtask

    initial begin
        rst             = 1'b1;
        idle();
        flush_target_i  = '0;
        branch_target_i = '0;

        // Reset, then free run
        step();
        step();
        expect_state("rst", 32'h0, 1'b0, 1'b0);
        check_eq("rst.ce", {31'b0, ce_o}, 32'h0);
        check_eq("rst.maddr", misalign_addr_o, 32'h0);
        rst = 1'b0;
        step();
        expect_state("run0", 32'h0, 1'b0, 1'b0);
        check_eq("run0.ce", {31'b0, ce_o}, 32'h1);
        step(); check_eq("run4", pc_o, 32'h4);
        step(); check_eq("run8", pc_o, 32'h8);

        // Plain branch
        branch_flag_i = 1'b1; branch_target_i = 32'h100;
        step(); expect_state("br", 32'h100, 1'b0, 1'b0);
        idle();
        step(); check_eq("br.next", pc_o, 32'h104);

        // Branch captured during a 3-cycle stall
        flush_i = 1'b1; flush_target_i = 32'h10;
        step(); check_eq("fl10", pc_o, 32'h10);
        idle();
        stall_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h200;
        step(); expect_state("stl1", 32'h10, 1'b1, 1'b0);
        check_eq("stl1.ce", {31'b0, ce_o}, 32'h1);
        branch_flag_i = 1'b0;
        step(); expect_state("stl2", 32'h10, 1'b1, 1'b0);
        step(); expect_state("stl3", 32'h10, 1'b1, 1'b0);
        stall_i = 1'b0;
        step(); expect_state("pend", 32'h200, 1'b0, 1'b0);
        step(); check_eq("pend.next", pc_o, 32'h204);

        // Flush beats stall and branch
        stall_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h300;
        flush_i = 1'b1; flush_target_i = 32'h80;
        step(); expect_state("flpri", 32'h80, 1'b0, 1'b0);
        idle();
        step(); check_eq("flpri.next", pc_o, 32'h84);

        // Misaligned flush target is forced aligned and reported
        flush_i = 1'b1; flush_target_i = 32'h83;
        step(); expect_state("flmis", 32'h80, 1'b0, 1'b1);
        check_eq("flmis.addr", misalign_addr_o, 32'h83);
        idle();
        step(); expect_state("flmis.next", 32'h84, 1'b0, 1'b0);

        // Misaligned live branch
        flush_i = 1'b1; flush_target_i = 32'h20;
        step(); check_eq("fl20", pc_o, 32'h20);
        idle();
        branch_flag_i = 1'b1; branch_target_i = 32'h102;
        step(); expect_state("brmis", 32'h24, 1'b0, 1'b1);
        check_eq("brmis.addr", misalign_addr_o, 32'h102);
        idle();
        step(); expect_state("brmis.next", 32'h28, 1'b0, 1'b0);
        check_eq("brmis.hold", misalign_addr_o, 32'h102);

        // Misaligned pending branch
        stall_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h106;
        step(); expect_state("pmis.cap", 32'h28, 1'b1, 1'b0);
        idle();
        step(); expect_state("pmis", 32'h2C, 1'b0, 1'b1);
        check_eq("pmis.addr", misalign_addr_o, 32'h106);
        step(); expect_state("pmis.next", 32'h30, 1'b0, 1'b0);

        // Live branch wins over pending; pending then discarded
        stall_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h400;
        step(); check_eq("live.cap", {31'b0, redirect_pending_o}, 32'h1);
        stall_i = 1'b0; branch_target_i = 32'h500;
        step(); expect_state("live", 32'h500, 1'b0, 1'b0);
        idle();
        step(); check_eq("live.next", pc_o, 32'h504);

        // Later capture overwrites earlier one
        stall_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h600;
        step();
        branch_target_i = 32'h700;
        step(); check_eq("ovr.hold", pc_o, 32'h504);
        idle();
        step(); expect_state("ovr", 32'h700, 1'b0, 1'b0);

        // Wrap-around
        flush_i = 1'b1; flush_target_i = 32'hFFFF_FFF8;
        step(); check_eq("wrap0", pc_o, 32'hFFFF_FFF8);
        idle();
        step(); check_eq("wrap1", pc_o, 32'hFFFF_FFFC);
        step(); check_eq("wrap2", pc_o, 32'h0000_0000);

        // Reset while a redirect is pending
        stall_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h900;
        step(); expect_state("rp.cap", 32'h0, 1'b1, 1'b0);
        idle();
        rst = 1'b1;
        step(); expect_state("rp.rst", 32'h0, 1'b0, 1'b0);
        check_eq("rp.ce", {31'b0, ce_o}, 32'h0);
        rst = 1'b0;
        step(); expect_state("rp.first", 32'h0, 1'b0, 1'b0);
        check_eq("rp.ce1", {31'b0, ce_o}, 32'h1);
        step(); check_eq("rp.seq", pc_o, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter generator and fetch-request controller; sits directly upstream of the IF stage.
- Drives the fetch address and chip-enable consumed by IF and the instruction ROM.
- Applies, in priority order, pipeline flush redirects from the controller, branch/jump redirects from ID, and stalls.
- Captures a branch redirect that arrives while the PC is stalled, so the redirect is never lost.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- ADDR_W, 32, width of PC and target buses.
- PC_STEP, 4, sequential increment in bytes (RV32I, no compressed instructions).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall_i  in  1  hold PC this cycle (pipeline controller stall bit for PC).
- flush_i  in  1  controller redirect (exception/trap); highest priority after rst.
- flush_target_i  in  ADDR_W  flush destination.
- branch_flag_i  in  1  ID-stage taken branch/jump.
- branch_target_i  in  ADDR_W  branch/jump destination.
- pc_o  out  ADDR_W  current fetch address (registered).
- ce_o  out  1  fetch enable to ROM/IF (registered).
- redirect_pending_o  out  1  high while a captured branch redirect is waiting.
- misalign_o  out  1  one-cycle pulse: rejected redirect target with target[1:0] != 0.
- misalign_addr_o  out  ADDR_W  offending target; valid while misalign_o is high.

Behaviour:
- Reset (rst=1 at edge):
  - pc_o=RESET_PC, ce_o=0, redirect_pending_o=0, misalign_o=0, misalign_addr_o=0.
  - Pending target register cleared; state goes to S_RST.
  - rst mid-operation discards any pending redirect or stall context.
- States: S_RST, S_RUN, S_PEND. redirect_pending_o = (state==S_PEND).
- S_RST, first edge with rst=0:
  - ce_o<=1 and state<=S_RUN.
  - pc_o stays RESET_PC, so RESET_PC is fetched exactly once.
  - All other inputs are ignored on this edge.
- S_RUN/S_PEND, per edge, first matching rule wins:
  1. flush_i=1:
     - Target aligned: pc_o<=flush_target_i.
     - Target misaligned: pc_o<=flush_target_i & ~3, misalign_o pulses, misalign_addr_o<=flush_target_i.
     - Pending cleared, state<=S_RUN. Overrides stall_i and branch_flag_i.
  2. stall_i=1:
     - pc_o holds.
     - If branch_flag_i=1: pending<=branch_target_i, state<=S_PEND. A later capture overwrites the earlier one.
     - Otherwise the state is unchanged.
  3. branch_flag_i=1: redirect to branch_target_i (live input wins over pending). Pending cleared, state<=S_RUN.
  4. state==S_PEND: redirect to the pending target, then clear; state<=S_RUN.
  5. Otherwise: pc_o<=pc_o+PC_STEP, modulo 2^ADDR_W (32'hFFFF_FFFC -> 32'h0000_0000).
- Branch redirect alignment (rules 3/4):
  - Target with [1:0]!=0 is rejected: pc_o<=pc_o+PC_STEP instead.
  - misalign_o=1 for exactly that cycle; misalign_addr_o<=target.
  - Pending cleared. The controller raises the exception and flushes.
- misalign_o is 0 on every edge not listed above. misalign_addr_o holds its last value.
- A misaligned capture during stall is stored as-is; the alignment check happens at consumption.
- ce_o stays 1 in S_RUN/S_PEND, including during stalls; the ROM is re-read at the held PC.
- Latency: a redirect presented at edge N is visible on pc_o after edge N. A stalled redirect appears one edge after stall_i deasserts.

Test Plan:
1. Reset, then run: rst=1 for 2 cycles, then release with no other inputs.
   - pc_o = 0, 0 (ce_o=1), 4, 8, C on successive edges.
   - ce_o=0 throughout reset.
2. Branch: at pc_o=8, branch_flag_i=1 with target 0x100 for one cycle.
   - Next pc_o=0x100, then 0x104.
3. Branch during stall:
   - pc_o=0x10; stall_i=1 for 3 cycles; branch_flag_i=1 with target 0x200 in stall cycle 1 only.
   - pc_o holds 0x10; redirect_pending_o=1 from the edge after capture.
   - After stall_i drops: pc_o=0x200, redirect_pending_o=0, then 0x204.
4. Flush priority:
   - Same edge: stall_i=1, branch_flag_i=1 (target 0x300), flush_i=1 (target 0x80).
   - pc_o=0x80; pending stays 0; next edge gives 0x84.
5. Misaligned branch: at pc_o=0x20, branch target 0x102.
   - pc_o=0x24; misalign_o=1 for one cycle; misalign_addr_o=0x102.
   - Repeat as a pending target: same result after the stall releases.
6. Wrap: flush to 0xFFFF_FFF8.
   - Sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
   - Assert rst while S_PEND: pending cleared, pc_o=RESET_PC.
